// File: rtl/vga_sprite_engine.sv
// vga_sprite_engine: VGA timing plus frame-latched sprite compositor with per-enemy explosion animation
module vga_sprite_engine #(
    parameter int HPIXELS        = 800,
    parameter int VLINES         = 521,
    parameter int HPULSE         = 96,
    parameter int VPULSE         = 2,
    parameter int HBP            = 144,
    parameter int HFP            = 784,
    parameter int VBP            = 31,
    parameter int VFP            = 511,
    parameter int COORD_W        = 10,
    parameter int N_ENEMY        = 5,
    parameter int ENEMY_SPACING  = 40,
    parameter int N_EPROJ        = 5,
    parameter int SPR_HALF       = 10,
    parameter int EXPLODE_FRAMES = 4
) (
    input  logic                         dclk,
    input  logic                         clr_n,
    input  logic                         play,
    input  logic [COORD_W-1:0]           player_x,
    input  logic [COORD_W-1:0]           player_y,
    input  logic [COORD_W-1:0]           enemy_x,
    input  logic [COORD_W-1:0]           enemy_y,
    input  logic [N_ENEMY-1:0]           collide,
    input  logic [COORD_W-1:0]           proj_x,
    input  logic [COORD_W-1:0]           proj_y,
    input  logic [N_EPROJ*COORD_W-1:0]   eproj_x,
    input  logic [N_EPROJ*COORD_W-1:0]   eproj_y,
    output logic                         hsync,
    output logic                         vsync,
    output logic [2:0]                   red,
    output logic [2:0]                   green,
    output logic [1:0]                   blue,
    output logic                         frame_tick
);
    localparam int CW = COORD_W;
    localparam int SW = COORD_W + 2;
    localparam int BW = $clog2(EXPLODE_FRAMES + 1);
    typedef logic signed [SW-1:0] sc_t;
    typedef enum logic [1:0] {IDLE, BOOM, DONE} boom_st_t;
    localparam logic [CW-1:0] H_LAST  = CW'(HPIXELS - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(VLINES - 1);
    localparam logic [CW-1:0] H_PULSE = CW'(HPULSE);
    localparam logic [CW-1:0] V_PULSE = CW'(VPULSE);
    localparam logic [CW-1:0] H_BP    = CW'(HBP);
    localparam logic [CW-1:0] H_FP    = CW'(HFP);
    localparam logic [CW-1:0] V_BP    = CW'(VBP);
    localparam logic [CW-1:0] V_FP    = CW'(VFP);
    localparam sc_t L_COL  = sc_t'(80);
    localparam sc_t R_COL  = sc_t'(560);
    localparam sc_t BAN_X0 = sc_t'(200);
    localparam sc_t BAN_X1 = sc_t'(355);
    localparam sc_t BAN_Y0 = sc_t'(200);
    localparam sc_t BAN_Y1 = sc_t'(225);
    localparam sc_t HALF   = sc_t'(SPR_HALF);
    localparam sc_t PR_HX  = sc_t'(5);
    localparam sc_t PR_HY  = sc_t'(10);
    localparam logic [7:0] WHITE  = 8'hff;
    localparam logic [7:0] RED    = 8'he0;
    localparam logic [7:0] YELLOW = 8'hfc;

    // zero-extend a screen coordinate into the signed geometry domain so off-screen centres never wrap
    function automatic sc_t sx(input logic [CW-1:0] v);
        return sc_t'({2'b00, v});
    endfunction

    function automatic logic inr(input sc_t p, input sc_t lo, input sc_t hi);
        return p >= lo && p <= hi;
    endfunction

    function automatic logic inbox(input sc_t p, input sc_t c, input sc_t h);
        return inr(p, c - h, c + h);
    endfunction

    // explosion grows by 10 per elapsed frame from a 5-pixel start
    function automatic sc_t boom_half(input logic [BW-1:0] b);
        return sc_t'(5 + 10 * EXPLODE_FRAMES) - sc_t'(10) * sc_t'(b);
    endfunction

    logic [CW-1:0]         hc, vc;
    logic                  s_play;
    logic [CW-1:0]         s_plx, s_ply, s_enx, s_eny, s_prx, s_pry;
    logic [N_ENEMY-1:0]    s_col;
    logic [N_EPROJ*CW-1:0] s_epx, s_epy;
    boom_st_t              st [N_ENEMY];
    logic [BW-1:0]         boom [N_ENEMY];
    sc_t                   bx [N_ENEMY];
    sc_t                   by [N_ENEMY];
    logic                  frame_end, active;
    sc_t                   px, py;
    logic [7:0]            rgb;

    assign frame_end = hc == H_LAST && vc == V_LAST;
    assign active    = hc >= H_BP && hc < H_FP && vc >= V_BP && vc < V_FP;

    // raster scan counters
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            hc <= '0;
            vc <= '0;
        end else begin
            hc <= (hc == H_LAST) ? '0 : hc + 1'b1;
            if (hc == H_LAST) vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
        end
    end

    // copy game inputs once per frame so a frame never mixes old and new positions
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            s_play <= 1'b0;
            s_plx  <= '0;
            s_ply  <= '0;
            s_enx  <= '0;
            s_eny  <= '0;
            s_col  <= '0;
            s_prx  <= '0;
            s_pry  <= '0;
            s_epx  <= '0;
            s_epy  <= '0;
        end else if (frame_end) begin
            s_play <= play;
            s_plx  <= player_x;
            s_ply  <= player_y;
            s_enx  <= enemy_x;
            s_eny  <= enemy_y;
            s_col  <= collide;
            s_prx  <= proj_x;
            s_pry  <= proj_y;
            s_epx  <= eproj_x;
            s_epy  <= eproj_y;
        end
    end

    // per-enemy explosion sequencer, advanced only at the frame latch point
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < N_ENEMY; i++) begin
                st[i]   <= IDLE;
                boom[i] <= '0;
                bx[i]   <= '0;
                by[i]   <= '0;
            end
        end else if (frame_end) begin
            for (int i = 0; i < N_ENEMY; i++) begin
                case (st[i])
                    IDLE: if (collide[i] && !s_col[i]) begin
                        st[i]   <= BOOM;
                        boom[i] <= BW'(EXPLODE_FRAMES);
                        bx[i]   <= sx(enemy_x) + sc_t'(i * ENEMY_SPACING);
                        by[i]   <= sx(enemy_y);
                    end
                    BOOM: begin
                        st[i]   <= !collide[i] ? IDLE : (boom[i] == BW'(1)) ? DONE : BOOM;
                        boom[i] <= !collide[i] ? '0 : boom[i] - 1'b1;
                    end
                    default: st[i] <= collide[i] ? DONE : IDLE;
                endcase
            end
        end
    end

    // layered colour decision, later layers overwrite earlier ones
    always_comb begin
        px  = sx(hc) - sc_t'(HBP);
        py  = sx(vc) - sc_t'(VBP);
        rgb = (px < L_COL || px >= R_COL) ? WHITE : 8'h00;
        if (!s_play && inr(px, BAN_X0, BAN_X1) && inr(py, BAN_Y0, BAN_Y1)) rgb = WHITE;
        if (inbox(px, sx(s_plx), HALF) && inbox(py, sx(s_ply), HALF)) rgb = WHITE;
        for (int i = 0; i < N_ENEMY; i++)
            if (!s_col[i] && inbox(px, sx(s_enx) + sc_t'(i * ENEMY_SPACING), HALF) && inbox(py, sx(s_eny), HALF)) rgb = RED;
        for (int i = 0; i < N_ENEMY; i++)
            if (st[i] == BOOM && inbox(px, bx[i], boom_half(boom[i])) && inbox(py, by[i], boom_half(boom[i]))) rgb = YELLOW;
        if (s_pry <= s_ply && inbox(px, sx(s_prx), PR_HX) && inbox(py, sx(s_pry), PR_HY)) rgb = WHITE;
        for (int k = 0; k < N_EPROJ; k++)
            if (s_epy[k*CW +: CW] != '0 && inbox(px, sx(s_epx[k*CW +: CW]), PR_HX) && inbox(py, sx(s_epy[k*CW +: CW]), PR_HY)) rgb = RED;
        if (!active) rgb = 8'h00;
    end

    // single output register stage keeps colour and syncs aligned
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            hsync              <= 1'b1;
            vsync              <= 1'b1;
            {red, green, blue} <= '0;
            frame_tick         <= 1'b0;
        end else begin
            hsync              <= hc >= H_PULSE;
            vsync              <= vc >= V_PULSE;
            {red, green, blue} <= rgb;
            frame_tick         <= hc == '0 && vc == '0;
        end
    end
endmodule

// File: doc/vga_sprite_engine.md
Name: vga_sprite_engine

Overview:
- Parametrised successor to the single-frame VGA colour generator: VGA timing, plus a sprite compositor with N enemies and M enemy projectiles.
- Adds frame-synchronous shadow latching of all sprite inputs (no mid-frame tearing) and per-enemy explosion animation counters.
- Adds registered RGB/sync outputs.
- Sits between game logic (positions, collide flags) and the board VGA pins.

Parameters:
- HPIXELS, 800, pixels per line
- VLINES, 521, lines per frame
- HPULSE, 96, hsync low length (pixels)
- VPULSE, 2, vsync low length (lines)
- HBP, 144, first active column
- HFP, 784, first column after active
- VBP, 31, first active line
- VFP, 511, first line after active
- COORD_W, 10, coordinate width
- N_ENEMY, 5, enemy count (row formation)
- ENEMY_SPACING, 40, x pitch between enemies
- N_EPROJ, 5, enemy projectile count
- SPR_HALF, 10, sprite half-size (player, enemy)
- EXPLODE_FRAMES, 4, explosion length in frames

Ports:
- dclk  in  1  pixel clock, 25 MHz
- clr_n  in  1  asynchronous active-low reset
- play  in  1  0 = title screen, 1 = game
- player_x, player_y  in  COORD_W each  player centre
- enemy_x, enemy_y  in  COORD_W each  enemy 0 centre; enemy i at x + i*ENEMY_SPACING
- collide  in  N_ENEMY  bit i = enemy i destroyed
- proj_x, proj_y  in  COORD_W each  player projectile centre
- eproj_x, eproj_y  in  N_EPROJ*COORD_W each  packed enemy projectiles; slot k = bits [k*COORD_W +: COORD_W]
- hsync, vsync  out  1  active-low syncs
- red  out  3  red
- green  out  3  green
- blue  out  2  blue
- frame_tick  out  1  one-cycle pulse at hc=0, vc=0

Behaviour:
- Reset (clr_n low, async): hc=vc=0; all shadows 0; boom counters 0; hsync=vsync=1; RGB=0; frame_tick=0.

Counters and syncs:
- hc counts 0..HPIXELS-1; at wrap, vc increments 0..VLINES-1 and wraps.
- Raw hsync = (hc >= HPULSE); raw vsync = (vc >= VPULSE).
- Active region: HBP <= hc < HFP and VBP <= vc < VFP. Pixel coords px = hc-HBP, py = vc-VBP.

Pipeline:
- The colour decision is combinational on (hc, vc, shadows); RGB, hsync, vsync and frame_tick are all registered.
- Fixed latency: 1 dclk from counter state to pins.
- Syncs are delayed by the same register stage, so alignment is preserved.

Shadow latch:
- At hc=HPIXELS-1, vc=VLINES-1, all position, play and collide inputs are copied into shadows.
- Drawing uses shadows only. Input changes mid-frame take effect the next frame.

Explosion FSM, per enemy i:
- IDLE: on shadow collide[i] 0->1 (compared with the previous frame's shadow), latch centre (enemy_x + i*ENEMY_SPACING, enemy_y); boom[i] = EXPLODE_FRAMES; go to BOOM.
- BOOM: boom[i] decrements at each shadow latch; at 0 go to DONE. Square half-size = 5 + 10*(EXPLODE_FRAMES - boom[i]); colour yellow (111, 111, 00).
- DONE: draws nothing; return to IDLE when collide[i]=0.
- collide 1->0 during BOOM aborts to IDLE.

Colour priority, lowest to highest:
- Base: inside active region, columns px<80 and px>=560 are white; all else is black.
- play=0: title banner, white rectangle px 200..355, py 200..225 inclusive.
- Player: white square, |px-x|<=SPR_HALF and |py-y|<=SPR_HALF.
- Enemy i: red (111, 000, 00), drawn only if collide[i]=0.
- Explosions.
- Player projectile: white 11x21 box (±5 x, ±10 y), shown only if proj_y <= player_y.
- Enemy projectile k: red 11x21 box, shown only if y_k != 0.

Blanking and geometry rules:
- Outside the active region, RGB = 0.
- All box comparisons use COORD_W+2 bit signed arithmetic, so a centre near 0 does not wrap. Sprites partly off-screen are clipped, not wrapped.

Test Plan:
- Reset release, then run 2 frames: hsync low exactly 96 of every 800 dclk; vsync low exactly 2 lines of 521; frame_tick once per 416800 dclk.
- player_x=100, player_y=100, play=1: white at px 90..110, py 90..110; black at px 89 and 111. RGB appears 1 dclk after the matching hc/vc.
- Change player_x 100->300 at vc=200: rest of frame still shows x=100; next frame shows x=300.
- enemy_x=200, enemy_y=50, collide=00100 after a frame of 00000: enemy 2 missing. Yellow half-sizes 5, 15, 25, 35 over 4 frames, then nothing. Other enemies red at x 200, 240, 320, 360.
- eproj slot 3 y=0, x=300: no pixel drawn. Set y=120: red box px 295..305, py 110..130. Player projectile with proj_y > player_y: hidden.
- Assert clr_n low at hc=400, vc=300: outputs go to reset values immediately. After release, counting restarts at 0,0 and shadows are 0.
